// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : shifter_pkg
// Description : Shared types and helpers for the universal sequential shifter:
//               operation encoding, controller state encoding and a helper
//               that tells multi-cycle shift operations from one-cycle ones.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int c_op_w = 3;

    // Operation codes as presented on the command interface
    typedef enum logic [c_op_w-1:0] {
        OP_NOP  = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ASR  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ROL  = 3'd6,
        OP_CLR  = 3'd7
    } shift_op_t;

    // Controller states: IDLE accepts commands, RUN steps one bit per cycle
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shift_state_t;

    // True for the operations that move data one bit per cycle
    function automatic logic is_shift_op(input shift_op_t op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_universal_seq_if.sv
`default_nettype none
// ============================================================================
// Interface   : shifter_universal_seq_if
// Description : Command / data bundle of the universal sequential shifter.
//               The master drives commands and serial fill bits, the slave
//               (the shifter) returns register contents and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface shifter_universal_seq_if #(
    parameter int WIDTH = 8
);
    import shifter_pkg::*;

    localparam int AW = $clog2(WIDTH + 1);

    logic             i_valid;
    logic             o_ready;
    shift_op_t        i_op;
    logic [AW-1:0]    i_amt;
    logic [WIDTH-1:0] i_pdata;
    logic             i_sdata_lt;
    logic             i_sdata_rt;
    logic             i_abort;
    logic [WIDTH-1:0] o_pdata;
    logic             o_sdata_lt;
    logic             o_sdata_rt;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_valid, i_op, i_amt, i_pdata, i_sdata_lt, i_sdata_rt, i_abort,
        input  o_ready, o_pdata, o_sdata_lt, o_sdata_rt, o_busy, o_done
    );

    modport slave (
        input  i_valid, i_op, i_amt, i_pdata, i_sdata_lt, i_sdata_rt, i_abort,
        output o_ready, o_pdata, o_sdata_lt, o_sdata_rt, o_busy, o_done
    );

endinterface
`default_nettype wire

// File: rtl/shifter_universal_step.sv
`default_nettype none
// ============================================================================
// Module      : shifter_universal_step
// Description : Purely combinational single-bit step of the universal shifter.
//               Non-shift operations pass the data through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_universal_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  shift_op_t        i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sdata_lt,
    input  logic             i_sdata_rt,
    output logic [WIDTH-1:0] o_data
);

    // One-bit move; fill bits come from the serial inputs or the data itself
    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SHR:  o_data = {i_sdata_rt, i_data[WIDTH-1:1]};
            OP_SHL:  o_data = {i_data[WIDTH-2:0], i_sdata_lt};
            OP_ASR:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            OP_ROR:  o_data = {i_data[0], i_data[WIDTH-1:1]};
            OP_ROL:  o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shifter_universal_seq.sv
`default_nettype none
// ============================================================================
// Module      : shifter_universal_seq
// Description : Universal sequential shift register. LOAD/CLR/NOP complete in
//               the accept cycle; shift and rotate commands run one bit per
//               cycle for a clamped count, can be aborted, and signal
//               completion with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_universal_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input wire logic              i_clk,
    input wire logic              i_rst_n,
    shifter_universal_seq_if.slave bus
);

    localparam int AW = $clog2(WIDTH + 1);

    // Largest meaningful count; anything above it shifts the full width
    localparam logic [AW-1:0] c_amt_max = AW'(WIDTH);
    localparam logic [AW-1:0] c_cnt_one = AW'(1);

    shift_state_t     r_state;
    shift_op_t        r_op;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_pdata;
    logic             r_done;

    logic [AW-1:0]    w_amt_clamped;
    logic [WIDTH-1:0] w_step_data;
    logic             w_accept;
    logic             w_start_run;

    // Clamp the requested count and classify the incoming command
    always_comb begin
        w_amt_clamped = (bus.i_amt > c_amt_max) ? c_amt_max : bus.i_amt;
        w_accept      = bus.i_valid && (r_state == ST_IDLE);
        w_start_run   = is_shift_op(bus.i_op) && (w_amt_clamped != '0);
    end

    shifter_universal_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op       (r_op),
        .i_data     (r_pdata),
        .i_sdata_lt (bus.i_sdata_lt),
        .i_sdata_rt (bus.i_sdata_rt),
        .o_data     (w_step_data)
    );

    // Controller: accept in IDLE, one step per cycle in RUN, registered done
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
            r_pdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (bus.i_op)
                            OP_LOAD: r_pdata <= bus.i_pdata;
                            OP_CLR:  r_pdata <= '0;
                            default: r_pdata <= r_pdata;
                        endcase
                        if (w_start_run) begin
                            // Data stays put here; the first step happens next edge
                            r_op    <= bus.i_op;
                            r_cnt   <= w_amt_clamped;
                            r_state <= ST_RUN;
                        end else begin
                            // One-cycle commands and zero-length shifts finish now
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.i_abort) begin
                        // Keep the partial result, no step, no done pulse
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pdata <= w_step_data;
                        r_cnt   <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Status and serial outputs follow the registers directly
    always_comb begin
        bus.o_ready    = (r_state == ST_IDLE);
        bus.o_busy     = (r_state == ST_RUN);
        bus.o_done     = r_done;
        bus.o_pdata    = r_pdata;
        bus.o_sdata_lt = r_pdata[0];
        bus.o_sdata_rt = r_pdata[WIDTH-1];
    end

endmodule
`default_nettype wire

// File: doc/shifter_universal_seq.md
SHIFTER_UNIVERSAL_SEQ -- requirements
Module: shifter_universal_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have derived localparam AW = $clog2(WIDTH+1), shift-amount width.
REQ-003 SHALL have port i_clk  input  1  clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  command valid.
REQ-006 SHALL have port o_ready  output  1  command accepted when i_valid && o_ready.
REQ-007 SHALL have port i_op  input  3  operation code (REQ-013).
REQ-008 SHALL have port i_amt  input  AW  shift count; values >WIDTH clamp to WIDTH.
REQ-009 SHALL have ports i_pdata  input  WIDTH  parallel load data; i_sdata_lt  input  1  serial fill at LSB; i_sdata_rt  input  1  serial fill at MSB.
REQ-010 SHALL have port i_abort  input  1  cancel an in-progress shift.
REQ-011 SHALL have ports o_pdata  output  WIDTH  register contents; o_sdata_lt  output  1  = o_pdata[0]; o_sdata_rt  output  1  = o_pdata[WIDTH-1].
REQ-012 SHALL have ports o_busy  output  1  shift in progress; o_done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode i_op: 0 NOP, 1 SHR logical (MSB <- i_sdata_rt), 2 SHL (LSB <- i_sdata_lt), 3 LOAD (<- i_pdata), 4 ASR (MSB kept), 5 ROR, 6 ROL, 7 CLR (<- 0).
REQ-014 SHALL implement FSM states IDLE and RUN; o_ready = (state==IDLE), o_busy = (state==RUN).
REQ-015 SHALL, on acceptance of NOP/LOAD/CLR, update o_pdata at that edge, stay IDLE, and pulse o_done the following cycle.
REQ-016 SHALL, on acceptance of a shift op (1,2,4,5,6) with clamped amt N>=1, latch op and N, enter RUN, leave o_pdata unchanged at the accept edge.
REQ-017 SHALL, in RUN, perform exactly one 1-bit step per cycle, sampling i_sdata_lt/i_sdata_rt live each step; N steps take N cycles.
REQ-018 SHALL return to IDLE at the edge performing step N and assert o_done for the single cycle after it.
REQ-019 SHALL treat a shift op with i_amt==0 as NOP: no data change, o_done pulse next cycle.
REQ-020 SHALL ignore i_valid, i_op, i_amt, i_pdata while in RUN.
REQ-021 SHALL, on i_abort in RUN, perform no step that cycle, retain partially shifted o_pdata, return to IDLE, and not assert o_done; i_abort in IDLE has no effect.
REQ-022 SHALL allow a new command to be accepted in the same cycle o_done is high (back-to-back, zero bubble).
REQ-023 SHALL produce o_sdata_lt/o_sdata_rt combinationally from o_pdata every cycle, including mid-shift.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously force o_pdata=0, state=IDLE, step counter=0, o_done=0; hence o_ready=1, o_busy=0.
REQ-025 SHALL abandon any in-progress shift on reset with no o_done pulse after reset release.
REQ-026 SHALL accept a command in the first cycle after reset deassertion.

Structure
REQ-027 SHALL take shift_op_t (3-bit op enum) and shift_state_t (IDLE, RUN) from shared package shifter_pkg.
REQ-028 SHALL instantiate one combinational sub-module shifter_universal_step (WIDTH, op, data, sdata_lt, sdata_rt -> next data) computing a single 1-bit step.
REQ-029 SHALL keep the step counter AW bits wide, decrementing to zero, with no wrap.

Verification (WIDTH=8)
REQ-030 SHALL cover: LOAD 0xA5 -> o_pdata=0xA5 after accept edge, o_done next cycle, o_sdata_lt=1, o_sdata_rt=1.
REQ-031 SHALL cover: from 0x81, ROR amt=3 -> o_busy 3 cycles, o_pdata 0xC0, 0x60, 0x30, o_done once, o_ready back high.
REQ-032 SHALL cover: from 0x80, ASR amt=12 (clamped 8) -> 0xFF after 8 cycles; from 0x01, SHL amt=2 with i_sdata_lt=1 -> 0x07.
REQ-033 SHALL cover: SHR amt=5 from 0xF0, i_sdata_rt=0, i_abort on 3rd RUN cycle -> o_pdata=0x3C, no o_done, o_ready=1.
REQ-034 SHALL cover: i_rst_n low mid-ROL -> o_pdata=0 immediately, no o_done after release; LOAD 0x3C back-to-back with a done pulse accepted with zero bubble.
